// File: rtl/mem_access_pkg.sv
// Shared types for the memory-stage access unit: FSM state, default bus
// timeout and the control bundle that travels with each instruction.
package mem_access_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       RF_WE;
    logic       MemWE;
    logic       WBSelect;
    logic [3:0] A3;
  } ctrl_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding bus transaction; hit_o flags the last
// permitted cycle (count == LIMIT-1) while counting is enabled.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned W = $clog2(LIMIT);

  logic [W-1:0] cnt_q;

  assign hit_o = en_i && (cnt_q == W'(LIMIT - 1));

  always_ff @(posedge CLK) begin
    if (RST || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !hit_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: runs a req/ack data-bus transaction for
// loads/stores, stalls upstream meanwhile, and registers the MEM/WB result.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         valid_i,
  input  logic         MemWE_i,
  input  logic         MemRE_i,
  input  logic [N-1:0] AluResult_i,
  input  logic [N-1:0] WriteData_i,
  input  logic         RF_WE_i,
  input  logic         WBSelect_i,
  input  logic [3:0]   A3_i,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [N-1:0] mem_rdata_i,
  output logic         stall_o,
  output logic         valid_o,
  output logic [N-1:0] ReadData_o,
  output logic [N-1:0] AluResult_o,
  output logic         RF_WE_o,
  output logic         MemWE_o,
  output logic         WBSelect_o,
  output logic [3:0]   A3_o,
  output logic         err_o
);

  state_t       state_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic         we_q;
  ctrl_t        ctrl_lat_q;
  logic         req_q;
  logic         err_q;
  logic         valid_q;
  logic [N-1:0] rdata_q;
  logic [N-1:0] alu_q;
  ctrl_t        ctrl_out_q;

  logic  mem_op;
  logic  timeout_hit;
  ctrl_t in_ctrl;

  assign mem_op  = valid_i && (MemWE_i || MemRE_i);
  assign in_ctrl = '{RF_WE: RF_WE_i, MemWE: MemWE_i, WBSelect: WBSelect_i, A3: A3_i};

  mem_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (state_q == IDLE),
    .en_i  (state_q == BUSY),
    .hit_o (timeout_hit)
  );

  // NOTE: stall is combinational so upstream freezes in the acceptance cycle itself.
  assign stall_o = ((state_q == IDLE) && mem_op) ||
                   ((state_q == BUSY) && !mem_ack_i && !timeout_hit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ctrl_lat_q <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      alu_q      <= '0;
      ctrl_out_q <= '0;
    end else begin
      // Output side defaults to a bubble; only completions overwrite it.
      valid_q    <= 1'b0;
      rdata_q    <= '0;
      alu_q      <= '0;
      ctrl_out_q <= '0;
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            addr_q     <= AluResult_i;
            wdata_q    <= WriteData_i;
            we_q       <= MemWE_i;
            ctrl_lat_q <= in_ctrl;
            req_q      <= 1'b1;
            state_q    <= BUSY;
          end else if (valid_i) begin
            valid_q    <= 1'b1;
            alu_q      <= AluResult_i;
            ctrl_out_q <= in_ctrl;
          end
        end
        BUSY: begin
          // NOTE: ack is tested first so a same-cycle timeout never discards a real completion.
          if (mem_ack_i) begin
            valid_q    <= 1'b1;
            alu_q      <= addr_q;
            rdata_q    <= we_q ? '0 : mem_rdata_i;
            ctrl_out_q <= ctrl_lat_q;
            req_q      <= 1'b0;
            state_q    <= IDLE;
          end else if (timeout_hit) begin
            valid_q    <= 1'b1;
            alu_q      <= addr_q;
            ctrl_out_q <= '{RF_WE: 1'b0, MemWE: 1'b0,
                            WBSelect: ctrl_lat_q.WBSelect, A3: ctrl_lat_q.A3};
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign valid_o     = valid_q;
  assign ReadData_o  = rdata_q;
  assign AluResult_o = alu_q;
  assign RF_WE_o     = ctrl_out_q.RF_WE;
  assign MemWE_o     = ctrl_out_q.MemWE;
  assign WBSelect_o  = ctrl_out_q.WBSelect;
  assign A3_o        = ctrl_out_q.A3;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// random transactions checked against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int N  = 32;
  localparam int TO = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         valid_i, MemWE_i, MemRE_i, RF_WE_i, WBSelect_i;
  logic [N-1:0] AluResult_i, WriteData_i;
  logic [3:0]   A3_i;
  logic         mem_req_o, mem_we_o;
  logic [N-1:0] mem_addr_o, mem_wdata_o;
  logic         mem_ack_i;
  logic [N-1:0] mem_rdata_i;
  logic         stall_o, valid_o;
  logic [N-1:0] ReadData_o, AluResult_o;
  logic         RF_WE_o, MemWE_o, WBSelect_o;
  logic [3:0]   A3_o;
  logic         err_o;

  mem_access_unit #(.N(N), .TIMEOUT(TO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .valid_i     (valid_i),
    .MemWE_i     (MemWE_i),
    .MemRE_i     (MemRE_i),
    .AluResult_i (AluResult_i),
    .WriteData_i (WriteData_i),
    .RF_WE_i     (RF_WE_i),
    .WBSelect_i  (WBSelect_i),
    .A3_i        (A3_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .ReadData_o  (ReadData_o),
    .AluResult_o (AluResult_o),
    .RF_WE_o     (RF_WE_o),
    .MemWE_o     (MemWE_o),
    .WBSelect_o  (WBSelect_o),
    .A3_o        (A3_o),
    .err_o       (err_o)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic err_exp  = 1'b0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i     = 1'b0;
    MemWE_i     = 1'b0;
    MemRE_i     = 1'b0;
    AluResult_i = '0;
    WriteData_i = '0;
    RF_WE_i     = 1'b0;
    WBSelect_i  = 1'b0;
    A3_i        = '0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [N-1:0] rd,
                           input logic [N-1:0] alu, input logic rfwe, input logic mwe,
                           input logic wbs, input logic [3:0] a3);
    check({tag, "_valid"}, valid_o, v);
    check({tag, "_rdata"}, ReadData_o, rd);
    check({tag, "_alu"}, AluResult_o, alu);
    check({tag, "_rfwe"}, RF_WE_o, rfwe);
    check({tag, "_memwe"}, MemWE_o, mwe);
    check({tag, "_wbsel"}, WBSelect_o, wbs);
    check({tag, "_a3"}, A3_o, a3);
  endtask

  task automatic check_all_zero(input string tag);
    check_out(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    check({tag, "_req"}, mem_req_o, 1'b0);
    check({tag, "_we"}, mem_we_o, 1'b0);
    check({tag, "_addr"}, mem_addr_o, '0);
    check({tag, "_wdata"}, mem_wdata_o, '0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    tick();
    tick();
    RST     = 1'b0;
    err_exp = 1'b0;
  endtask

  // One instruction from presentation to its MEM/WB result. k is the ack delay
  // in cycles after req rises; k >= TO means the bus never answers.
  task automatic run_op(input string tag, input logic we, input logic re,
                        input logic [N-1:0] addr, input logic [N-1:0] wdata,
                        input logic rfwe, input logic wbs, input logic [3:0] a3,
                        input int k, input logic [N-1:0] rdata);
    int   stalls;
    logic acked;
    logic done;
    valid_i     = 1'b1;
    MemWE_i     = we;
    MemRE_i     = re;
    AluResult_i = addr;
    WriteData_i = wdata;
    RF_WE_i     = rfwe;
    WBSelect_i  = wbs;
    A3_i        = a3;
    #1;
    if (!(we || re)) begin
      check({tag, "_alu_stall"}, stall_o, 1'b0);
      tick();
      idle_inputs();
      check_out(tag, 1'b1, '0, addr, rfwe, 1'b0, wbs, a3);
      return;
    end
    stalls = stall_o ? 1 : 0;
    tick();
    acked = 1'b0;
    done  = 1'b0;
    for (int j = 0; j < TO && !done; j++) begin
      check({tag, "_req"}, mem_req_o, 1'b1);
      check({tag, "_addr"}, mem_addr_o, addr);
      check({tag, "_we"}, mem_we_o, we);
      check({tag, "_wdata"}, mem_wdata_o, wdata);
      check({tag, "_bubble"}, valid_o, 1'b0);
      if (j == k) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        acked       = 1'b1;
      end else begin
        mem_rdata_i = $urandom;
      end
      #1;
      if (stall_o) stalls++;
      if (j == k || j == TO - 1) done = 1'b1;
      tick();
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
    end
    idle_inputs();
    check({tag, "_stall_cycles"}, stalls, acked ? k + 1 : TO);
    if (acked) begin
      check_out(tag, 1'b1, we ? '0 : rdata, addr, rfwe, we, wbs, a3);
    end else begin
      err_exp = 1'b1;
      check_out({tag, "_to"}, 1'b1, '0, addr, 1'b0, 1'b0, wbs, a3);
    end
    check({tag, "_req_done"}, mem_req_o, 1'b0);
    check({tag, "_err"}, err_o, err_exp);
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;

    do_reset();
    check_all_zero("reset");
    #1;
    check("reset_stall", stall_o, 1'b0);

    run_op("alu", 1'b0, 1'b0, 32'h0000_1234, '0, 1'b1, 1'b0, 4'd5, 0, '0);
    run_op("load", 1'b0, 1'b1, 32'h0000_0100, '0, 1'b1, 1'b1, 4'd7, 3, 32'hDEAD_BEEF);
    run_op("store", 1'b1, 1'b0, 32'h0000_0200, 32'h0000_CAFE, 1'b0, 1'b0, 4'd0, 0, 32'h1111_2222);

    run_op("tmo", 1'b0, 1'b1, 32'h0000_0300, '0, 1'b1, 1'b1, 4'd9, 99, '0);
    tick();
    check("tmo_err_sticky", err_o, 1'b1);
    run_op("post_tmo_alu", 1'b0, 1'b0, 32'h0000_0042, '0, 1'b1, 1'b0, 4'd3, 0, '0);

    run_op("b2b_0", 1'b0, 1'b1, 32'h0000_0400, '0, 1'b1, 1'b1, 4'd1, 0, 32'h0BAD_F00D);
    run_op("b2b_1", 1'b0, 1'b1, 32'h0000_0404, '0, 1'b1, 1'b1, 4'd2, 0, 32'h1234_5678);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("stray_stall", stall_o, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    check_out("stray", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("stray_req", mem_req_o, 1'b0);

    valid_i     = 1'b1;
    MemRE_i     = 1'b1;
    AluResult_i = 32'h0000_0500;
    RF_WE_i     = 1'b1;
    WBSelect_i  = 1'b1;
    A3_i        = 4'd4;
    tick();
    check("rst_busy_req", mem_req_o, 1'b1);
    tick();
    RST = 1'b1;
    idle_inputs();
    tick();
    RST     = 1'b0;
    err_exp = 1'b0;
    check_all_zero("rst_busy");
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hABCD_0123;
    #1;
    check("late_ack_stall", stall_o, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    check("late_ack_valid", valid_o, 1'b0);
    check("late_ack_req", mem_req_o, 1'b0);
    check("late_ack_rdata", ReadData_o, '0);

    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic        we, re;
      logic [N-1:0] a, wd, rd;
      logic [3:0]  a3;
      kind = $urandom_range(0, 3);
      we   = (kind == 2) || (kind == 3);
      re   = (kind == 1) || (kind == 3);
      a    = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      a3   = 4'($urandom_range(0, 15));
      run_op("rnd", we, re, a, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             a3, $urandom_range(0, 5), rd);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("rnd_gap_valid", valid_o, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
